// File: rtl/clk_period_monitor.sv
// Measures the rising-edge period of a slow or derived signal in clk cycles,
// declares lock after a run of in-tolerance periods, and flags lost lock.
module clk_period_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int EXP_PERIOD  = 12,
  parameter int TOL         = 1,
  parameter int LOCK_COUNT  = 4,
  parameter int TIMEOUT     = 64,
  parameter int CW          = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          mon_in,
  input  logic          enable,
  input  logic          clear_fault,
  output logic          locked,
  output logic          fault,
  output logic [CW-1:0] period,
  output logic          period_valid,
  output logic [7:0]    fault_count
);

  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT);
  localparam logic [GW-1:0] LCK = GW'(LOCK_COUNT);
  localparam int LO = EXP_PERIOD - TOL;
  localparam int HI = EXP_PERIOD + TOL;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    TRACK,
    LOCKED
  } state_t;

  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic prev_q, prev_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [GW-1:0] good_q, good_d;
  logic [GW-1:0] good_inc;
  logic locked_q, locked_d;
  logic fault_q, fault_d;
  logic [CW-1:0] period_q, period_d;
  logic pv_q, pv_d;
  logic [7:0] fcnt_q, fcnt_d;
  logic rise, tmo, good, fevt;

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign tmo = (cnt_q == TMO) & ~rise;
  assign good = (int'(cnt_q) >= LO) && (int'(cnt_q) <= HI);
  assign good_inc = good_q + 1'b1;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], mon_in};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_comb begin
    cnt_d = cnt_q;
    if (!enable || state_q == IDLE) begin
      cnt_d = '0;
    end else if (rise) begin
      cnt_d = CW'(1);
    end else if (cnt_q != TMO) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    good_d = good_q;
    locked_d = locked_q;
    period_d = period_q;
    pv_d = 1'b0;
    fevt = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      good_d = '0;
      locked_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: state_d = ARM;
        ARM: begin
          if (rise) begin
            state_d = TRACK;
            good_d = '0;
          end
        end
        TRACK: begin
          if (rise) begin
            period_d = cnt_q;
            pv_d = 1'b1;
            if (good) begin
              good_d = good_inc;
              if (good_inc == LCK) begin
                state_d = LOCKED;
                locked_d = 1'b1;
              end
            end else begin
              good_d = '0;
            end
          end else if (tmo) begin
            state_d = ARM;
            good_d = '0;
          end
        end
        LOCKED: begin
          if (rise) begin
            period_d = cnt_q;
            pv_d = 1'b1;
            if (!good) begin
              state_d = TRACK;
              good_d = '0;
              locked_d = 1'b0;
              fevt = 1'b1;
            end
          end else if (tmo) begin
            state_d = ARM;
            good_d = '0;
            locked_d = 1'b0;
            fevt = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // A new fault event beats a simultaneous clear.
  always_comb begin
    fault_d = (fault_q & ~clear_fault) | fevt;
    fcnt_d = fcnt_q;
    if (fevt && fcnt_q != 8'hFF) begin
      fcnt_d = fcnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sync_q <= '0;
      prev_q <= 1'b0;
      cnt_q <= '0;
      good_q <= '0;
      locked_q <= 1'b0;
      fault_q <= 1'b0;
      period_q <= '0;
      pv_q <= 1'b0;
      fcnt_q <= '0;
    end else begin
      state_q <= state_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
      cnt_q <= cnt_d;
      good_q <= good_d;
      locked_q <= locked_d;
      fault_q <= fault_d;
      period_q <= period_d;
      pv_q <= pv_d;
      fcnt_q <= fcnt_d;
    end
  end

  assign locked = locked_q;
  assign fault = fault_q;
  assign period = period_q;
  assign period_valid = pv_q;
  assign fault_count = fcnt_q;

endmodule

// File: tb/tb_clk_period_monitor.sv
// Bench for clk_period_monitor: scenario table, saturation run, random
// periods against an edge-timestamp reference model, async reset.
module tb_clk_period_monitor;

  localparam int S = 2;
  localparam int EXP = 12;
  localparam int TOL = 1;
  localparam int LCK = 4;
  localparam int TMO = 64;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic reset;
  logic mon_in;
  logic enable;
  logic clear_fault;
  logic locked;
  logic fault;
  logic [CW-1:0] period;
  logic period_valid;
  logic [7:0] fault_count;

  always #5 clk = ~clk;

  clk_period_monitor #(
    .SYNC_STAGES(S),
    .EXP_PERIOD(EXP),
    .TOL(TOL),
    .LOCK_COUNT(LCK),
    .TIMEOUT(TMO),
    .CW(CW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .mon_in(mon_in),
    .enable(enable),
    .clear_fault(clear_fault),
    .locked(locked),
    .fault(fault),
    .period(period),
    .period_valid(period_valid),
    .fault_count(fault_count)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: remembers sampled input history and the edge index of
  // the last detected rise; period = edges elapsed since that rise.
  bit hq[$];
  int n;
  int m_last;
  bit m_run, m_ref, m_locked, m_fault, m_pv;
  int m_good, m_period, m_fc;

  function automatic bit samp(input int back);
    int idx;
    idx = hq.size() - 1 - back;
    return (idx >= 0) ? hq[idx] : 1'b0;
  endfunction

  task automatic model_reset();
    hq.delete();
    n = 0;
    m_last = 0;
    m_run = 0;
    m_ref = 0;
    m_locked = 0;
    m_fault = 0;
    m_pv = 0;
    m_good = 0;
    m_period = 0;
    m_fc = 0;
  endtask

  task automatic model_step();
    bit rise, ev, ok;
    int el;
    hq.push_back(mon_in);
    if (hq.size() > 8) void'(hq.pop_front());
    rise = samp(S) & ~samp(S + 1);
    el = n - m_last;
    if (el > TMO) el = TMO;
    ok = (el >= EXP - TOL) && (el <= EXP + TOL);
    m_pv = 0;
    ev = 0;
    if (!enable) begin
      m_run = 0;
      m_ref = 0;
      m_good = 0;
      m_locked = 0;
    end else if (!m_run) begin
      m_run = 1;
    end else if (!m_ref) begin
      if (rise) begin
        m_ref = 1;
        m_good = 0;
      end
    end else if (rise) begin
      m_period = el;
      m_pv = 1;
      if (ok) begin
        if (!m_locked) begin
          m_good++;
          if (m_good == LCK) m_locked = 1;
        end
      end else begin
        ev = m_locked;
        m_locked = 0;
        m_good = 0;
      end
    end else if (el >= TMO) begin
      ev = m_locked;
      m_ref = 0;
      m_good = 0;
      m_locked = 0;
    end
    if (rise) m_last = n;
    if (ev) begin
      m_fault = 1;
      if (m_fc < 255) m_fc++;
    end else if (clear_fault) begin
      m_fault = 0;
    end
    n++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("locked", int'(locked), int'(m_locked));
    chk("fault", int'(fault), int'(m_fault));
    chk("period", int'(period), m_period);
    chk("period_valid", int'(period_valid), int'(m_pv));
    chk("fault_count", int'(fault_count), m_fc);
  endtask

  // per==0: hold mon_in low for reps cycles.
  task automatic run_per(input int per, input int reps, input int clr_off,
                         input bit en);
    int len;
    len = (per == 0) ? reps : per * reps;
    for (int c = 0; c < len; c++) begin
      mon_in = (per == 0) ? 1'b0 : ((c % per) < (per / 2));
      clear_fault = (c == clr_off);
      enable = en;
      tick();
    end
    clear_fault = 1'b0;
  endtask

  task automatic chk_outs_zero(input string tag);
    chk({tag, "_locked"}, int'(locked), 0);
    chk({tag, "_fault"}, int'(fault), 0);
    chk({tag, "_period"}, int'(period), 0);
    chk({tag, "_pv"}, int'(period_valid), 0);
    chk({tag, "_fcnt"}, int'(fault_count), 0);
  endtask

  typedef struct {
    int per;
    int reps;
    int clr_off;
    bit en;
    bit exp_locked;
    bit exp_fault;
    int exp_fc;
    int exp_period;
  } seg_t;

  seg_t tbl[12];

  initial begin
    tbl[0]  = '{12, 6, -1, 1'b1, 1'b1, 1'b0, 0, 12};
    tbl[1]  = '{13, 1, -1, 1'b1, 1'b1, 1'b0, 0, 12};
    tbl[2]  = '{14, 1, -1, 1'b1, 1'b1, 1'b0, 0, 13};
    tbl[3]  = '{12, 5, -1, 1'b1, 1'b1, 1'b1, 1, 12};
    tbl[4]  = '{0, 80, -1, 1'b1, 1'b0, 1'b1, 2, 12};
    tbl[5]  = '{12, 6, -1, 1'b1, 1'b1, 1'b1, 2, 12};
    tbl[6]  = '{12, 2, -1, 1'b0, 1'b0, 1'b1, 2, 12};
    tbl[7]  = '{12, 6, -1, 1'b1, 1'b1, 1'b1, 2, 12};
    tbl[8]  = '{12, 2, 5, 1'b1, 1'b1, 1'b0, 2, 12};
    tbl[9]  = '{20, 1, -1, 1'b1, 1'b1, 1'b0, 2, 12};
    tbl[10] = '{12, 2, S, 1'b1, 1'b0, 1'b1, 3, 12};
    tbl[11] = '{12, 4, 5, 1'b1, 1'b1, 1'b0, 3, 12};

    reset = 1'b1;
    mon_in = 1'b0;
    enable = 1'b0;
    clear_fault = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_outs_zero("por");
    @(negedge clk);
    reset = 1'b0;
    run_per(0, 4, -1, 1'b1);

    for (int i = 0; i < 12; i++) begin
      run_per(tbl[i].per, tbl[i].reps, tbl[i].clr_off, tbl[i].en);
      chk($sformatf("seg%0d_locked", i), int'(locked), int'(tbl[i].exp_locked));
      chk($sformatf("seg%0d_fault", i), int'(fault), int'(tbl[i].exp_fault));
      chk($sformatf("seg%0d_fcnt", i), int'(fault_count), tbl[i].exp_fc);
      chk($sformatf("seg%0d_period", i), int'(period), tbl[i].exp_period);
    end

    // Repeated lock / bad-period cycles drive the fault counter to saturation.
    for (int i = 0; i < 300; i++) begin
      run_per(20, 1, -1, 1'b1);
      run_per(12, 4, -1, 1'b1);
    end
    run_per(12, 1, -1, 1'b1);
    chk("sat_fcnt", int'(fault_count), 255);
    chk("sat_fault", int'(fault), 1);

    for (int i = 0; i < 150; i++) begin
      int per, clr;
      bit en;
      per = int'($urandom_range(9, 15));
      en = ($urandom_range(0, 24) != 0);
      clr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, per - 1)) : -1;
      if ($urandom_range(0, 19) == 0) run_per(0, 70, -1, 1'b1);
      run_per(per, int'($urandom_range(1, 3)), clr, en);
    end

    run_per(0, 4, -1, 1'b1);
    run_per(12, 7, -1, 1'b1);
    chk("pre_rst_locked", int'(locked), 1);
    #3;
    reset = 1'b1;
    #1;
    chk_outs_zero("async_rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    run_per(12, 6, -1, 1'b1);
    chk("post_rst_locked", int'(locked), 1);
    chk("post_rst_fcnt", int'(fault_count), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
